// File: rtl/zybo_button_conditioner.sv
// Button/switch conditioner: 2FF sync, per-channel debounce FSM, registered level and edge pulses.
// Optional auto-repeat pulses are compiled in with `define ZYBO_BTN_AUTOREPEAT_EN.
module zybo_button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int REPEAT_DELAY    = 62500000,
  parameter int REPEAT_PERIOD   = 12500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] rise,
  output logic [NUM_BTN-1:0] fall,
  output logic [NUM_BTN-1:0] repeat_pulse
);
  // state   | meaning
  // LOW     | accepted level 0, input agrees
  // RISING  | input 1 for cnt cycles, waiting to accept
  // HIGH    | accepted level 1, input agrees
  // FALLING | input 0 for cnt cycles, waiting to accept
  typedef enum logic [1:0] {ST_LOW, ST_RISING, ST_HIGH, ST_FALLING} state_t;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("zybo_button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  (* ASYNC_REG = "TRUE" *) logic [NUM_BTN-1:0] r_sync1;
  (* ASYNC_REG = "TRUE" *) logic [NUM_BTN-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar c = 0; c < NUM_BTN; c++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_level, r_rise, r_fall;
    logic             w_level_nxt, w_rise_nxt, w_fall_nxt;
    logic             w_sync;

    assign w_sync = r_sync2[c];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_LOW;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_level <= w_level_nxt;
        r_rise  <= w_rise_nxt;
        r_fall  <= w_fall_nxt;
      end
    end

    // Counter restarts on every state entry and is only compared for equality.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_LOW: if (w_sync) begin
          w_state_nxt = ST_RISING;
          w_cnt_nxt   = CNT_ONE;
        end
        ST_RISING: if (!w_sync) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_MAX) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
        ST_HIGH: if (!w_sync) begin
          w_state_nxt = ST_FALLING;
          w_cnt_nxt   = CNT_ONE;
        end
        ST_FALLING: if (w_sync) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_MAX) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
        default: begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_comb begin
      w_level_nxt = r_level;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      if (r_state == ST_RISING && w_sync && r_cnt == DEB_MAX) begin
        w_level_nxt = 1'b1;
        w_rise_nxt  = 1'b1;
      end
      if (r_state == ST_FALLING && !w_sync && r_cnt == DEB_MAX) begin
        w_level_nxt = 1'b0;
        w_fall_nxt  = 1'b1;
      end
    end

    assign level[c] = r_level;
    assign rise[c]  = r_rise;
    assign fall[c]  = r_fall;

`ifdef ZYBO_BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DLY_M1  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PER_M1  = REP_W'(REPEAT_PERIOD - 1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    logic [REP_W-1:0] r_rcnt;
    logic             r_rphase;
    logic             r_rep;
    logic [REP_W-1:0] w_rep_tgt;

    assign w_rep_tgt = r_rphase ? PER_M1 : DLY_M1;

    // Counts HIGH cycles; holds through FALLING so a rejected release resumes the schedule.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rcnt   <= '0;
        r_rphase <= 1'b0;
        r_rep    <= 1'b0;
      end else if (r_state == ST_HIGH) begin
        if (r_rcnt == w_rep_tgt) begin
          r_rcnt   <= '0;
          r_rphase <= 1'b1;
          r_rep    <= 1'b1;
        end else begin
          r_rcnt   <= r_rcnt + REP_ONE;
          r_rep    <= 1'b0;
        end
      end else begin
        r_rep <= 1'b0;
        if (r_state == ST_RISING || w_state_nxt == ST_LOW) begin
          r_rcnt   <= '0;
          r_rphase <= 1'b0;
        end
      end
    end

    assign repeat_pulse[c] = r_rep;
`else
    assign repeat_pulse[c] = 1'b0;
`endif
  end

endmodule
